arbiter_client_driver: RTL and testbench
========================================

Name: arbiter_client_driver

Overview:
- Requester-side counterpart to the 3-channel mutual-exclusion arbiter on the user IO pads.
- For each channel it drives a 4-phase return-to-zero request line and synchronises the arbiter's asynchronous grant line.
- On grant it holds a programmable critical section, then releases and waits for the grant to drop.
- It also checks grant mutual exclusion and keeps per-channel grant statistics, giving on-chip stimulus and self-checking for the arbiter.

Parameters:
- BITS, 3, number of request/grant channels
- TIMEOUT, 255, maximum synchronised cycles a request waits for grant before abort (≥1)
- CNT_W, 8, width of each per-channel grant counter

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_ni  in  1  asynchronous active-low reset
- start_i  in  BITS  per-channel one-cycle start pulse
- hold_cycles_i  in  8  critical-section length in cycles, shared by all channels
- clr_err_i  in  1  synchronous clear of sticky error flags and counters
- grant_i  in  BITS  asynchronous grants from arbiter (pad side)
- req_o  out  BITS  request lines to arbiter (pad side)
- busy_o  out  BITS  channel not IDLE
- done_o  out  BITS  one-cycle pulse on successful completion
- timeout_o  out  BITS  sticky: request aborted after TIMEOUT
- proto_err_o  out  BITS  sticky: synced grant high while channel IDLE
- mutex_err_o  out  1  sticky: more than one synced grant high in the same cycle
- grant_cnt_o  out  BITS*CNT_W  per-channel saturating count of grants received; channel k occupies bits [k*CNT_W +: CNT_W]

Behaviour:
- Reset is asynchronous and active-low.
  - Reset values: all outputs 0, all FSMs IDLE, synchronisers 0, counters 0.
  - Deassertion is used directly. Reset mid-handshake drops req_o immediately.
- Grant sync: 2-flop synchroniser per channel. gs[k] lags grant_i[k] by 2 edges. The FSM and checkers use only gs.
- Channel FSM, states IDLE, REQ, HOLD, RELEASE:
  - IDLE: if start_i[k], go to REQ; req_o[k]=1 from the next cycle. If gs[k]=1 in IDLE, set proto_err_o[k].
  - REQ: req_o=1 and the wait counter increments each cycle.
    - If gs[k]=1, go to HOLD, load the hold counter with max(hold_cycles_i,1), and increment grant_cnt[k] (saturating at 2^CNT_W−1).
    - Else, when the wait counter reaches TIMEOUT, set timeout_o[k] and go to RELEASE.
  - HOLD: req_o=1. Decrement the hold counter. When it reaches 0, go to RELEASE. The number of HOLD cycles equals max(hold_cycles_i,1). hold_cycles_i is sampled only on entry to HOLD.
  - RELEASE: req_o=0. When gs[k]=0, go to IDLE. done_o[k] pulses on that transition only if the pass did not time out.
    - After a timeout, RELEASE still waits for gs[k]=0, so a late grant is correctly retired.
- start_i[k] while busy is ignored (not queued).
- Simultaneous starts on all channels are legal; each channel is independent.
- mutex_err_o is set in any cycle where popcount(gs)>1.
- clr_err_i clears timeout_o, proto_err_o, mutex_err_o and grant_cnt.
  - If clr_err_i and a set condition occur in the same cycle, the set wins.
  - clr_err_i does not affect the FSMs.
- Latency: start_i to req_o = 1 cycle. grant_i edge to HOLD entry = 3 cycles (2 sync + 1 FSM). Last HOLD cycle to req_o low = 1 cycle.
- TIMEOUT counting: the counter clears on REQ entry. Abort happens on the cycle the counter equals TIMEOUT, i.e. TIMEOUT+1 cycles after req rise.

Decomposition:
- Package arbiter_client_pkg holds:
  - the state typedef (IDLE/REQ/HOLD/RELEASE)
  - SYNC_STAGES=2
  - the hold-counter width constant 8
- Sub-module arbiter_client_chan: one channel's FSM, hold/wait counters, grant counter and per-channel stickies, instantiated BITS times.
- The top level holds the synchronisers and the mutex checker.

Test Plan:
- Single channel (modelled arbiter grants 2 cycles after req): start_i=3'b001, hold_cycles_i=4 → req_o[0] up 1 cycle later; 4 HOLD cycles; req_o[0] drops; done_o[0] pulses once; grant_cnt[0]=1.
- Contention: start_i=3'b111 with a fair arbiter model → three sequential grants, three done pulses, each grant_cnt=1, mutex_err_o=0.
- Timeout (TIMEOUT=10, grant held 0): start ch1 → req_o[1] high 11 cycles then low; timeout_o[1]=1; no done_o[1]; FSM returns to IDLE.
- Late grant after timeout: grant_i[1] rises 2 cycles after the abort and falls 5 cycles later → channel stays busy until synced grant falls; no proto_err_o.
- Faults: force grant_i=3'b011 → mutex_err_o=1 within 3 cycles. grant_i[2]=1 with ch2 IDLE → proto_err_o[2]=1. Pulse clr_err_i with faults removed → all clear.
- Reset mid-HOLD (hold_cycles_i=200, assert wb_rst_ni=0 at cycle 50) → req_o=0 asynchronously and all outputs 0. After release, start_i=3'b001 completes normally; grant_cnt[0] reads 1, not 2.

Source files
------------

// File: rtl/arbiter_client_pkg.sv
// Shared types and constants for the arbiter client driver.
package arbiter_client_pkg;

    // Per-channel handshake phases
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } chan_state_e;

    // Depth of the grant synchroniser chain
    localparam int SYNC_STAGES = 2;

    // Width of the critical-section (hold) counter
    localparam int HOLD_W = 8;

    // Number of set bits in a vector (used by the grant mutual-exclusion check)
    function automatic int unsigned popcount(input logic [31:0] vec);
        int unsigned cnt;
        cnt = 32'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {31'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/arbiter_client_chan.sv
// One requester channel: 4-phase request FSM, wait/hold counters,
// saturating grant counter and sticky timeout/protocol flags.
module arbiter_client_chan
    import arbiter_client_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              gs,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic              clr_err,
    output logic              req,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              proto_err,
    output logic [CNT_W-1:0]  grant_cnt
);

    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    chan_state_e       state_r, state_nx_s;
    logic [WAIT_W-1:0] wait_r, wait_nx_s;
    logic [HOLD_W-1:0] hold_r, hold_nx_s;
    logic              aborted_r, aborted_nx_s;
    logic              set_to_s, set_proto_s, grant_inc_s, done_s;
    logic              req_r, busy_r, done_r, timeout_r, proto_err_r;
    logic [CNT_W-1:0]  grant_cnt_r;

    // Next-state and event decode for the handshake FSM
    always_comb begin
        state_nx_s   = state_r;
        wait_nx_s    = wait_r;
        hold_nx_s    = hold_r;
        aborted_nx_s = aborted_r;
        set_to_s     = 1'b0;
        set_proto_s  = 1'b0;
        grant_inc_s  = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A grant while we are not requesting is an arbiter fault
                set_proto_s = gs;
                if (start) begin
                    state_nx_s   = ST_REQ;
                    wait_nx_s    = WAIT_ZERO;
                    aborted_nx_s = 1'b0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // Grant takes priority over an abort in the same cycle
                if (gs) begin
                    state_nx_s  = ST_HOLD;
                    hold_nx_s   = (hold_cycles == HOLD_ZERO) ? HOLD_ONE : hold_cycles;
                    grant_inc_s = 1'b1;
                end else if (wait_r == WAIT_MAX) begin
                    state_nx_s   = ST_RELEASE;
                    set_to_s     = 1'b1;
                    aborted_nx_s = 1'b1;
                end else begin
                    wait_nx_s = wait_r + WAIT_ONE;
                end
            end
            ST_HOLD: begin
                hold_nx_s = hold_r - HOLD_ONE;
                if (hold_r == HOLD_ONE) begin
                    state_nx_s = ST_RELEASE;
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end
            ST_RELEASE: begin
                // Wait for the grant to drop, even after an abort (late grant)
                if (!gs) begin
                    state_nx_s = ST_IDLE;
                    done_s     = !aborted_r;
                end else begin
                    state_nx_s = ST_RELEASE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and working counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            wait_r    <= WAIT_ZERO;
            hold_r    <= HOLD_ZERO;
            aborted_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            wait_r    <= wait_nx_s;
            hold_r    <= hold_nx_s;
            aborted_r <= aborted_nx_s;
        end
    end

    // Registered outputs, sticky flags (set beats clear) and grant counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            timeout_r   <= 1'b0;
            proto_err_r <= 1'b0;
            grant_cnt_r <= CNT_ZERO;
        end else begin
            req_r  <= (state_nx_s == ST_REQ) || (state_nx_s == ST_HOLD);
            busy_r <= (state_nx_s != ST_IDLE);
            done_r <= done_s;
            if (set_to_s) begin
                timeout_r <= 1'b1;
            end else if (clr_err) begin
                timeout_r <= 1'b0;
            end else begin
                timeout_r <= timeout_r;
            end
            if (set_proto_s) begin
                proto_err_r <= 1'b1;
            end else if (clr_err) begin
                proto_err_r <= 1'b0;
            end else begin
                proto_err_r <= proto_err_r;
            end
            if (grant_inc_s) begin
                if (clr_err) begin
                    grant_cnt_r <= CNT_ONE;
                end else if (grant_cnt_r != CNT_MAX) begin
                    grant_cnt_r <= grant_cnt_r + CNT_ONE;
                end else begin
                    grant_cnt_r <= grant_cnt_r;
                end
            end else if (clr_err) begin
                grant_cnt_r <= CNT_ZERO;
            end else begin
                grant_cnt_r <= grant_cnt_r;
            end
        end
    end

    assign req       = req_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign timeout   = timeout_r;
    assign proto_err = proto_err_r;
    assign grant_cnt = grant_cnt_r;

endmodule

// File: rtl/arbiter_client_driver.sv
// Requester-side driver for the multi-channel mutual-exclusion arbiter:
// grant synchronisers, mutual-exclusion checker and one FSM per channel.
module arbiter_client_driver
    import arbiter_client_pkg::*;
#(
    parameter int BITS    = 3,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic [BITS-1:0]       start_i,
    input  logic [HOLD_W-1:0]     hold_cycles_i,
    input  logic                  clr_err_i,
    input  logic [BITS-1:0]       grant_i,
    output logic [BITS-1:0]       req_o,
    output logic [BITS-1:0]       busy_o,
    output logic [BITS-1:0]       done_o,
    output logic [BITS-1:0]       timeout_o,
    output logic [BITS-1:0]       proto_err_o,
    output logic                  mutex_err_o,
    output logic [BITS*CNT_W-1:0] grant_cnt_o
);

    logic [SYNC_STAGES-1:0][BITS-1:0] sync_r;
    logic [BITS-1:0]                  gs_s;
    logic                             multi_grant_s;
    logic                             mutex_err_r;

    // Grant synchroniser chain; only the last stage is used downstream
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync_r <= {(SYNC_STAGES*BITS){1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], grant_i};
        end
    end

    assign gs_s          = sync_r[SYNC_STAGES-1];
    assign multi_grant_s = (popcount(32'(gs_s)) > 32'd1);

    // Sticky flag for two or more simultaneous synchronised grants
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            mutex_err_r <= 1'b0;
        end else if (multi_grant_s) begin
            mutex_err_r <= 1'b1;
        end else if (clr_err_i) begin
            mutex_err_r <= 1'b0;
        end else begin
            mutex_err_r <= mutex_err_r;
        end
    end

    assign mutex_err_o = mutex_err_r;

    for (genvar k = 0; k < BITS; k++) begin : g_chan
        arbiter_client_chan #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_chan (
            .clk         (wb_clk_i),
            .rst_n       (wb_rst_ni),
            .start       (start_i[k]),
            .gs          (gs_s[k]),
            .hold_cycles (hold_cycles_i),
            .clr_err     (clr_err_i),
            .req         (req_o[k]),
            .busy        (busy_o[k]),
            .done        (done_o[k]),
            .timeout     (timeout_o[k]),
            .proto_err   (proto_err_o[k]),
            .grant_cnt   (grant_cnt_o[k*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_arbiter_client_driver.sv
// Self-checking bench for arbiter_client_driver with a small behavioural
// round-robin arbiter that grants two cycles after it picks a request.
module tb_arbiter_client_driver;

    localparam int BITS  = 3;
    localparam int TO    = 24;
    localparam int CNT_W = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [BITS-1:0]       start;
    logic [7:0]            hold;
    logic                  clr;
    logic [BITS-1:0]       grant;
    logic [BITS-1:0]       req, busy, done, to_flag, perr;
    logic                  merr;
    logic [BITS*CNT_W-1:0] gcnt;

    int n_chk  = 0;
    int n_pass = 0;

    logic arb_en;
    int   arb_cur, arb_dly, arb_rr;
    logic arb_granted;

    typedef struct {
        int   ch;
        logic [7:0] hold;
        logic arb;
        int   exp_req;
        int   exp_busy;
        int   exp_done;
        int   exp_cnt;
        int   exp_to;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    arbiter_client_driver #(
        .BITS    (BITS),
        .TIMEOUT (TO),
        .CNT_W   (CNT_W)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_ni     (rst_n),
        .start_i       (start),
        .hold_cycles_i (hold),
        .clr_err_i     (clr),
        .grant_i       (grant),
        .req_o         (req),
        .busy_o        (busy),
        .done_o        (done),
        .timeout_o     (to_flag),
        .proto_err_o   (perr),
        .mutex_err_o   (merr),
        .grant_cnt_o   (gcnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic arb_reset();
        arb_cur     = -1;
        arb_dly     = 0;
        arb_rr      = 0;
        arb_granted = 1'b0;
        grant       = 3'b000;
    endtask

    // Behavioural arbiter: pick round-robin, grant 2 cycles later, drop when req drops
    task automatic arb_step();
        int c;
        if (!arb_en) return;
        if (arb_cur < 0) begin
            for (int i = 0; i < BITS; i++) begin
                c = (arb_rr + i) % BITS;
                if (arb_cur < 0 && req[c]) begin
                    arb_cur     = c;
                    arb_dly     = 2;
                    arb_granted = 1'b0;
                end
            end
        end else if (!arb_granted) begin
            arb_dly--;
            if (arb_dly == 0) begin
                grant[arb_cur] = 1'b1;
                arb_granted    = 1'b1;
            end
        end else if (!req[arb_cur]) begin
            grant[arb_cur] = 1'b0;
            arb_rr         = (arb_cur + 1) % BITS;
            arb_cur        = -1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        arb_step();
    endtask

    // One start pulse on channel ch; count req/busy cycles and done pulses until idle
    task automatic run_pass(input int ch, input logic [7:0] h,
                            output int nreq, output int nbusy, output int ndone);
        nreq  = 0;
        nbusy = 0;
        ndone = 0;
        hold  = h;
        start[ch] = 1'b1;
        tick();
        start = 3'b000;
        for (int i = 0; i < 200; i++) begin
            if (req[ch])  nreq++;
            if (busy[ch]) nbusy++;
            if (done[ch]) ndone++;
            if (!busy[ch]) break;
            tick();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq, nbusy, ndone;
        int dn [BITS];
        int seen_merr;

        // busy cycles = 5 REQ (2 model + 2 sync + 1 FSM) + N HOLD + 3 RELEASE (1 + 2 sync)
        vecs[0] = '{ch: 0, hold: 8'd4, arb: 1'b1, exp_req: 9,      exp_busy: 12,     exp_done: 1, exp_cnt: 1, exp_to: 0};
        vecs[1] = '{ch: 0, hold: 8'd0, arb: 1'b1, exp_req: 6,      exp_busy: 9,      exp_done: 1, exp_cnt: 2, exp_to: 0};
        vecs[2] = '{ch: 2, hold: 8'd7, arb: 1'b1, exp_req: 12,     exp_busy: 15,     exp_done: 1, exp_cnt: 1, exp_to: 0};
        vecs[3] = '{ch: 1, hold: 8'd1, arb: 1'b0, exp_req: TO + 1, exp_busy: TO + 2, exp_done: 0, exp_cnt: 0, exp_to: 1};
        vecs[4] = '{ch: 1, hold: 8'd2, arb: 1'b1, exp_req: 7,      exp_busy: 10,     exp_done: 1, exp_cnt: 1, exp_to: 1};

        rst_n  = 1'b0;
        start  = 3'b000;
        hold   = 8'd0;
        clr    = 1'b0;
        arb_en = 1'b0;
        arb_reset();

        // Reset state
        #23;
        chk("reset_outputs", int'({req, busy, done, to_flag, perr, merr}), 0);
        chk("reset_gcnt", int'(gcnt), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_reset_idle", int'({req, busy, done, to_flag, perr, merr}), 0);

        // Table-driven single-channel passes
        for (int i = 0; i < 5; i++) begin
            arb_en = vecs[i].arb;
            arb_reset();
            run_pass(vecs[i].ch, vecs[i].hold, nreq, nbusy, ndone);
            chk($sformatf("v%0d_req_cycles", i), nreq, vecs[i].exp_req);
            chk($sformatf("v%0d_busy_cycles", i), nbusy, vecs[i].exp_busy);
            chk($sformatf("v%0d_done", i), ndone, vecs[i].exp_done);
            chk($sformatf("v%0d_gcnt", i), int'(gcnt[vecs[i].ch*CNT_W +: CNT_W]), vecs[i].exp_cnt);
            chk($sformatf("v%0d_timeout", i), int'(to_flag[vecs[i].ch]), vecs[i].exp_to);
            tick();
            tick();
        end
        chk("table_no_errs", int'({perr, merr}), 0);

        // Late grant: arrives just too late for REQ, must be retired in RELEASE
        arb_en = 1'b0;
        arb_reset();
        start[1] = 1'b1;
        tick();
        start = 3'b000;
        repeat (TO - 1) tick();
        grant[1] = 1'b1;
        repeat (5) tick();
        chk("late_busy_held", int'(busy[1]), 1);
        chk("late_req_low", int'(req[1]), 0);
        grant[1] = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done[1]) ndone++;
            if (!busy[1]) break;
        end
        chk("late_idle", int'(busy[1]), 0);
        chk("late_no_done", ndone, 0);
        chk("late_no_proto", int'(perr[1]), 0);
        chk("late_gcnt", int'(gcnt[1*CNT_W +: CNT_W]), 1);

        // Contention: all three start together, round-robin model serves them in turn
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_before_cont", int'({to_flag, perr, merr}), 0);
        chk("clr_gcnt", int'(gcnt), 0);
        arb_en = 1'b1;
        arb_reset();
        hold  = 8'd1;
        start = 3'b111;
        tick();
        start = 3'b000;
        seen_merr = 0;
        for (int k = 0; k < BITS; k++) dn[k] = 0;
        for (int i = 0; i < 150; i++) begin
            for (int k = 0; k < BITS; k++) if (done[k]) dn[k]++;
            if (merr) seen_merr = 1;
            if (busy == 3'b000) break;
            tick();
        end
        chk("cont_idle", int'(busy), 0);
        for (int k = 0; k < BITS; k++) begin
            chk($sformatf("cont_done_ch%0d", k), dn[k], 1);
            chk($sformatf("cont_gcnt_ch%0d", k), int'(gcnt[k*CNT_W +: CNT_W]), 1);
        end
        chk("cont_no_mutex", seen_merr, 0);
        chk("cont_no_timeout", int'(to_flag), 0);

        // Faults: two grants at once, grant to an idle channel, clear behaviour
        arb_en = 1'b0;
        arb_reset();
        tick();
        grant = 3'b011;
        repeat (2) tick();
        chk("mutex_not_yet", int'(merr), 0);
        tick();
        chk("mutex_set", int'(merr), 1);
        chk("proto_ch01", int'(perr), 3);
        grant = 3'b100;
        repeat (3) tick();
        chk("proto_ch2", int'(perr), 7);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_vs_set_proto", int'(perr), 4);
        chk("clr_mutex", int'(merr), 0);
        grant = 3'b000;
        repeat (3) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_all_flags", int'({to_flag, perr, merr}), 0);
        chk("clr_all_gcnt", int'(gcnt), 0);

        // Reset in the middle of a long critical section
        arb_en = 1'b1;
        arb_reset();
        hold = 8'd200;
        start[0] = 1'b1;
        tick();
        start = 3'b000;
        repeat (49) tick();
        chk("midhold_req", int'(req[0]), 1);
        chk("midhold_gcnt", int'(gcnt[0 +: CNT_W]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", int'({req, busy, done, to_flag, perr, merr}), 0);
        chk("async_rst_gcnt", int'(gcnt), 0);
        arb_en = 1'b0;
        arb_reset();
        tick();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        arb_en = 1'b1;
        arb_reset();
        run_pass(0, 8'd4, nreq, nbusy, ndone);
        chk("after_rst_req_cycles", nreq, 9);
        chk("after_rst_done", ndone, 1);
        chk("after_rst_gcnt", int'(gcnt[0 +: CNT_W]), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
